// File: rtl/rf_operand_stage.sv
// 16 x 16-bit register file feeding the ALU a/b operand paths. R0 is hardwired to zero.
// Optional same-cycle write-to-read forwarding when RF_WRITE_BYPASS_EN is defined.
module rf_operand_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] src_reg1,
  input  logic [ADDR_W-1:0] src_reg2,
  input  logic [ADDR_W-1:0] dst_reg,
  input  logic              write_reg,
  input  logic [DATA_W-1:0] dst_data,
  output logic [DATA_W-1:0] src_data1,
  output logic [DATA_W-1:0] src_data2,
  output logic              r0_write_attempt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_any;
  logic              wr_data;

  assign wr_any  = write_reg;
  assign wr_data = write_reg && (dst_reg != '0);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_data) begin
      regs[dst_reg] <= dst_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_write_attempt <= 1'b0;
    end else if (wr_any && (dst_reg == '0)) begin
      r0_write_attempt <= 1'b1;
    end
  end

  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    if (src_reg1 != '0) stored1 = regs[src_reg1];
    if (src_reg2 != '0) stored2 = regs[src_reg2];
  end

`ifdef RF_WRITE_BYPASS_EN
  // Forward the in-flight write; gated by rst_n so reset still reads zero.
  logic fwd1;
  logic fwd2;

  assign fwd1 = rst_n && wr_data && (src_reg1 == dst_reg);
  assign fwd2 = rst_n && wr_data && (src_reg2 == dst_reg);

  always_comb begin
    src_data1 = stored1;
    src_data2 = stored2;
    if (fwd1) src_data1 = dst_data;
    if (fwd2) src_data2 = dst_data;
  end
`else
  always_comb begin
    src_data1 = stored1;
    src_data2 = stored2;
  end
`endif

endmodule

// File: tb/tb_rf_operand_stage.sv
// Self-checking bench for rf_operand_stage: directed table, hand sequences, random sweep vs array model.
module tb_rf_operand_stage;

  logic        clk;
  logic        rst_n;
  logic [3:0]  src_reg1;
  logic [3:0]  src_reg2;
  logic [3:0]  dst_reg;
  logic        write_reg;
  logic [15:0] dst_data;
  logic [15:0] src_data1;
  logic [15:0] src_data2;
  logic        r0_write_attempt;

  int errors = 0;
  int checks = 0;

  logic [15:0] mdl [16];
  logic        mdl_flag;

`ifdef RF_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  rf_operand_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .src_reg1         (src_reg1),
    .src_reg2         (src_reg2),
    .dst_reg          (dst_reg),
    .write_reg        (write_reg),
    .dst_data         (dst_data),
    .src_data1        (src_data1),
    .src_data2        (src_data2),
    .r0_write_attempt (r0_write_attempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
    mdl_flag = 1'b0;
  endtask

  // Expected read value before the edge, given the write currently being presented.
  function automatic logic [15:0] exp_read(input logic [3:0] a, input logic we,
                                           input logic [3:0] d, input logic [15:0] data);
    if (a == 4'd0) return 16'h0000;
    if (BYPASS && we && d != 4'd0 && a == d) return data;
    return mdl[a];
  endfunction

  task automatic mdl_edge(input logic we, input logic [3:0] d, input logic [15:0] data);
    if (we) begin
      if (d == 4'd0) mdl_flag = 1'b1;
      else mdl[d] = data;
    end
  endtask

  // Called at posedge+1: present inputs, check pre-edge reads, then take the edge.
  task automatic cycle(input logic [3:0] s1, input logic [3:0] s2, input logic we,
                       input logic [3:0] d, input logic [15:0] data, input string tag);
    src_reg1 = s1; src_reg2 = s2; write_reg = we; dst_reg = d; dst_data = data;
    #1;
    chk({tag, "_rd1"}, src_data1, exp_read(s1, we, d, data));
    chk({tag, "_rd2"}, src_data2, exp_read(s2, we, d, data));
    chk({tag, "_flag"}, {15'd0, r0_write_attempt}, {15'd0, mdl_flag});
    @(posedge clk);
    mdl_edge(we, d, data);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  dst;
    logic [15:0] data;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [15:0] exp1;
    logic [15:0] exp2;
    logic        exp_flag;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b1, 4'd3,  16'h1234, 4'd3,  4'd0,  16'h1234, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 4'd12, 16'hA5A5, 4'd3,  4'd12, 16'h1234, 16'hA5A5, 1'b0};
    vecs[2] = '{1'b0, 4'd0,  16'h0000, 4'd12, 4'd12, 16'hA5A5, 16'hA5A5, 1'b0};
    vecs[3] = '{1'b1, 4'd0,  16'hFFFF, 4'd0,  4'd3,  16'h0000, 16'h1234, 1'b1};
    vecs[4] = '{1'b0, 4'd9,  16'h7777, 4'd9,  4'd0,  16'h0000, 16'h0000, 1'b1};
    vecs[5] = '{1'b1, 4'd5,  16'hBEEF, 4'd5,  4'd12, 16'hBEEF, 16'hA5A5, 1'b1};
    vecs[6] = '{1'b1, 4'd12, 16'h0F0F, 4'd12, 4'd0,  16'h0F0F, 16'h0000, 1'b1};

    rst_n = 1'b0; src_reg1 = '0; src_reg2 = '0; dst_reg = '0; write_reg = 1'b0; dst_data = '0;
    mdl_clear();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_flag", {15'd0, r0_write_attempt}, 16'h0000);

    // Directed table: write on one edge, read back after it with write disabled.
    for (int i = 0; i < 7; i++) begin
      src_reg1 = vecs[i].s1; src_reg2 = vecs[i].s2;
      write_reg = vecs[i].we; dst_reg = vecs[i].dst; dst_data = vecs[i].data;
      @(posedge clk);
      mdl_edge(vecs[i].we, vecs[i].dst, vecs[i].data);
      #1;
      write_reg = 1'b0;
      #1;
      chk($sformatf("vec%0d_rd1", i), src_data1, vecs[i].exp1);
      chk($sformatf("vec%0d_rd2", i), src_data2, vecs[i].exp2);
      chk($sformatf("vec%0d_flag", i), {15'd0, r0_write_attempt}, {15'd0, vecs[i].exp_flag});
    end

    // Asynchronous reset: R5 holds BEEF and must drop without a clock edge.
    @(posedge clk); #1;
    src_reg1 = 4'd5; write_reg = 1'b0;
    #1;
    chk("pre_async_r5", src_data1, 16'hBEEF);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_r5_clear", src_data1, 16'h0000);
    mdl_clear();
    @(negedge clk) rst_n = 1'b1;
    for (int r = 0; r < 16; r++) begin
      src_reg1 = 4'(r); src_reg2 = 4'(15 - r);
      #1;
      chk($sformatf("reset_r%0d_p1", r), src_data1, 16'h0000);
      chk($sformatf("reset_r%0d_p2", r), src_data2, 16'h0000);
    end
    chk("reset_flag_clear", {15'd0, r0_write_attempt}, 16'h0000);

    // Same-cycle hazard on R7.
    @(posedge clk); #1;
    cycle(4'd7, 4'd7, 1'b1, 4'd7, 16'h0001, "r7_init");
    src_reg1 = 4'd7; src_reg2 = 4'd7; write_reg = 1'b1; dst_reg = 4'd7; dst_data = 16'h8000;
    #1;
    chk("hazard_pre_p1", src_data1, BYPASS ? 16'h8000 : 16'h0001);
    chk("hazard_pre_p2", src_data2, BYPASS ? 16'h8000 : 16'h0001);
    @(posedge clk); mdl_edge(1'b1, 4'd7, 16'h8000); #1;
    write_reg = 1'b0;
    #1;
    chk("hazard_post_p1", src_data1, 16'h8000);
    chk("hazard_post_p2", src_data2, 16'h8000);

    // Write disabled leaves R9 untouched.
    cycle(4'd9, 4'd9, 1'b0, 4'd9, 16'h7777, "wdis");
    src_reg1 = 4'd9;
    #1;
    chk("wdis_r9", src_data1, 16'h0000);

    // Write colliding with reset is discarded.
    write_reg = 1'b1; dst_reg = 4'd9; dst_data = 16'h1111;
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    mdl_clear();
    @(negedge clk);
    write_reg = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("collide_r9", src_data1, 16'h0000);
    chk("collide_flag", {15'd0, r0_write_attempt}, 16'h0000);

    // Random sweep against the array model.
    @(posedge clk); #1;
    for (int n = 0; n < 2000; n++) begin
      cycle(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)),
            4'($urandom_range(15)), 16'($urandom), "rand");
    end
    write_reg = 1'b0;
    for (int r = 0; r < 16; r++) begin
      src_reg1 = 4'(r);
      #1;
      chk($sformatf("final_r%0d", r), src_data1, (r == 0) ? 16'h0000 : mdl[r]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
